icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Miss-handling controller for the L1 instruction cache in fetch stage 1. It captures a cache miss and its address, then issues one block-aligned read request to lower memory. It collects the response beats into a full cache block and drives the single-cycle cache write. It also ensures a refill cancelled by a pipeline flush never writes stale state.

Parameters:
ADDR_W, 32, width of PC/miss address
BLOCK_W, 256, cache block width in bits (8 instructions x 32b)
BEAT_W, 64, memory response beat width; NUM_BEATS = BLOCK_W/BEAT_W (4 at default)
TIMEOUT_CYCLES, 64, max idle cycles between beats in FILL (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high; clock clk
flush_i  in  1  fetch flush/recovery; cancels cache write of in-flight refill
miss_i  in  1  L1I miss indication
missAddr_i  in  ADDR_W  miss PC
memReqValid_o  out  1  read request valid
memReqAddr_o  out  ADDR_W  block-aligned request address
memReqReady_i  in  1  memory accepts request
memRespValid_i  in  1  response beat valid
memRespData_i  in  BEAT_W  response beat data
wrEnable_o  out  1  cache fill write strobe
wrAddr_o  out  ADDR_W  fill address (block-aligned)
instBlock_o  out  BLOCK_W  assembled block
busy_o  out  1  high in any state except IDLE
timeout_o  out  1  one-cycle pulse on refill timeout

Behaviour:
- Alignment: addr = missAddr_i with low log2(BLOCK_W/8) bits cleared (5 at default).
- Reset: state=IDLE, beat counter=0, discard=0. All outputs 0, including instBlock_o and wrAddr_o.
- IDLE: if miss_i=1, latch the aligned address, clear discard and go to REQ. flush_i has no effect in IDLE.
- REQ:
  - memReqValid_o=1 and memReqAddr_o=latched addr.
  - Both are held stable until memReqReady_i=1, including when the ready arrives in the first REQ cycle.
  - On the handshake cycle, go to FILL with counter=0.
- FILL:
  - Each cycle with memRespValid_i=1, store the beat into bits [counter*BEAT_W +: BEAT_W] and increment the counter. Beat 0 is least significant.
  - On accepting beat NUM_BEATS-1: go to IDLE if discard=1, else go to WRITE.
  - Gaps between beats are allowed.
- WRITE: wrEnable_o=1 for exactly one cycle, with wrAddr_o=latched addr and instBlock_o=assembled block. Then go to DONE.
- DONE: one cycle in which miss_i is ignored, so the cache lookup re-evaluates. Then go to IDLE.
- Outside WRITE, wrEnable_o=0. wrAddr_o and instBlock_o hold their last values.
- flush_i:
  - In REQ or FILL, flush_i sets discard. The bus transaction still completes: the request stays held and all beats are consumed.
  - In WRITE or DONE, flush_i is ignored; the block is valid memory content.
- miss_i while busy is ignored; there is no queueing.
- memRespValid_i outside FILL is ignored and the data is dropped.
- Reset mid-operation returns to IDLE on the next edge. Late beats are ignored.
- Latency with ready on first REQ cycle and back-to-back beats: miss sampled at cycle 0 → wrEnable_o at cycle 6 → IDLE at cycle 8.

Optional Feature:
ICACHE_REFILL_TIMEOUT_EN
- Defined:
  - A counter runs in FILL and resets on every accepted beat.
  - When it reaches TIMEOUT_CYCLES, the block goes to IDLE, pulses timeout_o for 1 cycle, and performs no write.
  - Beats arriving afterward are ignored.
- Undefined: FILL waits indefinitely, timeout_o is tied 0, and no counter logic exists.

Test Plan:
1. miss_i=1, missAddr_i=0x00001234, ready same cycle, beats D0..D3 on cycles 2-5 → memReqAddr_o=0x00001220; wrEnable_o only at cycle 6 with wrAddr_o=0x00001220, instBlock_o={D3,D2,D1,D0}; busy_o low at cycle 8.
2. memReqReady_i delayed 3 cycles → memReqValid_o=1 and memReqAddr_o=0x00001220 stable for all 4 cycles; exactly one handshake.
3. flush_i pulsed after 2 beats of miss at 0x00000040 → remaining 2 beats consumed, wrEnable_o never asserts, IDLE after last beat; following miss at 0x00000080 refills normally.
4. Beats with 2-cycle gaps, and miss_i toggling while busy → same block assembled in order; no second request until back in IDLE.
5. reset asserted in FILL after beat 1 → next cycle all outputs 0, state IDLE; beats 2-3 ignored, no write.
6. With ICACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=16, only 1 beat returned → timeout_o pulses once 16 cycles after beat 0; no wrEnable_o; busy_o=0 next cycle.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache refill controller: one block-aligned read, beat assembly, single-cycle fill write.
// Optional refill timeout in FILL is enabled by defining ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned BLOCK_W        = 256,
  parameter int unsigned BEAT_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               miss_i,
  input  logic [ADDR_W-1:0]  missAddr_i,
  output logic               memReqValid_o,
  output logic [ADDR_W-1:0]  memReqAddr_o,
  input  logic               memReqReady_i,
  input  logic               memRespValid_i,
  input  logic [BEAT_W-1:0]  memRespData_i,
  output logic               wrEnable_o,
  output logic [ADDR_W-1:0]  wrAddr_o,
  output logic [BLOCK_W-1:0] instBlock_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int unsigned NUM_BEATS = BLOCK_W / BEAT_W;
  localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned OFF       = $clog2(BLOCK_W / 8);

  typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, DONE} state_t;

  state_t             state, stateNext;
  logic [ADDR_W-1:0]  addrReg, alignedAddr, wrAddrReg;
  logic [BLOCK_W-1:0] fillBuf, fillMerged, blockReg;
  logic [CNT_W-1:0]   beatCnt;
  logic               discard;
  logic               beatAccept, lastBeat, dropBlock, timeoutHit;
  int unsigned        beatBase;

  assign beatAccept = (state == FILL) && memRespValid_i;
  assign lastBeat   = beatAccept && (beatCnt == CNT_W'(NUM_BEATS - 1));
  // A flush arriving on the final beat must still suppress the write.
  assign dropBlock  = discard | flush_i;

  always_comb begin
    alignedAddr          = missAddr_i;
    alignedAddr[OFF-1:0] = '0;
  end

  always_comb begin
    beatBase   = beatCnt * BEAT_W;
    fillMerged = fillBuf;
    fillMerged[beatBase +: BEAT_W] = memRespData_i;
  end

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idleCnt;

  always_ff @(posedge clk) begin
    if (reset || state != FILL || beatAccept) idleCnt <= '0;
    else                                      idleCnt <= idleCnt + 1'b1;
  end

  assign timeoutHit = (state == FILL) && !memRespValid_i &&
                      (idleCnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o  = timeoutHit;
`else
  assign timeoutHit = 1'b0;
  assign timeout_o  = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (miss_i) stateNext = REQ;
      REQ:   if (memReqReady_i) stateNext = FILL;
      FILL: begin
        if (timeoutHit)    stateNext = IDLE;
        else if (lastBeat) stateNext = dropBlock ? IDLE : WRITE;
      end
      WRITE: stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addrReg   <= '0;
      wrAddrReg <= '0;
      fillBuf   <= '0;
      blockReg  <= '0;
      beatCnt   <= '0;
      discard   <= 1'b0;
    end else begin
      if (state == IDLE && miss_i) begin
        addrReg <= alignedAddr;
        discard <= 1'b0;
      end
      if ((state == REQ || state == FILL) && flush_i) discard <= 1'b1;
      if (state == REQ && memReqReady_i) beatCnt <= '0;
      if (beatAccept) begin
        fillBuf <= fillMerged;
        beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
      end
      if (lastBeat && !dropBlock) begin
        blockReg  <= fillMerged;
        wrAddrReg <= addrReg;
      end
    end
  end

  assign memReqValid_o = (state == REQ);
  assign memReqAddr_o  = (state == REQ) ? addrReg : '0;
  assign wrEnable_o    = (state == WRITE);
  assign wrAddr_o      = wrAddrReg;
  assign instBlock_o   = blockReg;
  assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl; timeout scenario runs when ICACHE_REFILL_TIMEOUT_EN is defined.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush_i = 1'b0;
  logic         miss_i = 1'b0;
  logic [31:0]  missAddr_i = '0;
  logic         memReqValid_o;
  logic [31:0]  memReqAddr_o;
  logic         memReqReady_i = 1'b0;
  logic         memRespValid_i = 1'b0;
  logic [63:0]  memRespData_i = '0;
  logic         wrEnable_o;
  logic [31:0]  wrAddr_o;
  logic [255:0] instBlock_o;
  logic         busy_o;
  logic         timeout_o;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] blk;
  } wr_t;

  wr_t         wrQ[$];
  logic [31:0] reqQ[$];
  wr_t         wrSeen;
  int          checks = 0;
  int          errors = 0;
  int          hsCount = 0;
  int          toSeen = 0;

  icache_refill_ctrl #(
    .ADDR_W(32), .BLOCK_W(256), .BEAT_W(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .miss_i(miss_i),
    .missAddr_i(missAddr_i), .memReqValid_o(memReqValid_o),
    .memReqAddr_o(memReqAddr_o), .memReqReady_i(memReqReady_i),
    .memRespValid_i(memRespValid_i), .memRespData_i(memRespData_i),
    .wrEnable_o(wrEnable_o), .wrAddr_o(wrAddr_o), .instBlock_o(instBlock_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkBeat(input int t, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(t) << 16) | 64'(b);
  endfunction

  function automatic logic [255:0] mkBlock(input int t);
    return {mkBeat(t, 3), mkBeat(t, 2), mkBeat(t, 1), mkBeat(t, 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (busy_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check(name, 1, 0);
    step();
  endtask

  task automatic pushWr(input logic [31:0] a, input logic [255:0] b);
    wr_t w;
    w.addr = a;
    w.blk  = b;
    wrQ.push_back(w);
  endtask

  // Normal refill: request accepted in the first REQ cycle, beats spaced by gap idle cycles.
  task automatic refill(input logic [31:0] a, input logic [31:0] al, input int t, input int gap);
    reqQ.push_back(al);
    pushWr(al, mkBlock(t));
    miss_i = 1'b1; missAddr_i = a; memReqReady_i = 1'b1;
    step();
    miss_i = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      memRespValid_i = 1'b1; memRespData_i = mkBeat(t, b);
      step();
      memRespValid_i = 1'b0;
      if (b < 3) repeat (gap) step();
    end
    waitIdle("refill_idle_timeout", 40);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (memReqValid_o && memReqReady_i) begin
        hsCount++;
        if (reqQ.size() == 0) check("unexpected_req", 1, 0);
        else check("req_addr", memReqAddr_o, reqQ.pop_front());
      end
      if (wrEnable_o) begin
        if (wrQ.size() == 0) check("unexpected_write", 1, 0);
        else begin
          wrSeen = wrQ.pop_front();
          check("wr_addr", wrAddr_o, wrSeen.addr);
          check("wr_block", instBlock_o, wrSeen.blk);
        end
      end
      if (timeout_o) toSeen++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hsBefore;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_reqValid", memReqValid_o, 0);
    check("rst_reqAddr", memReqAddr_o, 0);
    check("rst_wrEnable", wrEnable_o, 0);
    check("rst_wrAddr", wrAddr_o, 0);
    check("rst_block", instBlock_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_timeout", timeout_o, 0);
    step();

    // Test 1: latency with ready on first REQ cycle and back-to-back beats
    reqQ.push_back(32'h0000_1220);
    pushWr(32'h0000_1220, mkBlock(1));
    miss_i = 1'b1; missAddr_i = 32'h0000_1234; memReqReady_i = 1'b1;
    step();
    miss_i = 1'b0;
    @(negedge clk);
    check("t1_c1_reqValid", memReqValid_o, 1);
    check("t1_c1_reqAddr", memReqAddr_o, 32'h0000_1220);
    step();
    for (int b = 0; b < 4; b++) begin
      memRespValid_i = 1'b1; memRespData_i = mkBeat(1, b);
      @(negedge clk);
      check("t1_no_early_write", wrEnable_o, 0);
      step();
    end
    memRespValid_i = 1'b0; memReqReady_i = 1'b0;
    @(negedge clk);
    check("t1_c6_wrEnable", wrEnable_o, 1);
    step();
    @(negedge clk);
    check("t1_c7_wrEnable", wrEnable_o, 0);
    check("t1_c7_busy", busy_o, 1);
    step();
    @(negedge clk);
    check("t1_c8_busy", busy_o, 0);
    check("t1_c8_block_hold", instBlock_o, mkBlock(1));
    step();

    // Test 2: ready delayed three cycles; request must hold stable
    hsBefore = hsCount;
    reqQ.push_back(32'h0000_1220);
    pushWr(32'h0000_1220, mkBlock(2));
    miss_i = 1'b1; missAddr_i = 32'h0000_123F; memReqReady_i = 1'b0;
    step();
    miss_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memReqReady_i = 1'b1;
      @(negedge clk);
      check("t2_reqValid_held", memReqValid_o, 1);
      check("t2_reqAddr_held", memReqAddr_o, 32'h0000_1220);
      step();
    end
    memReqReady_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      memRespValid_i = 1'b1; memRespData_i = mkBeat(2, b);
      step();
    end
    memRespValid_i = 1'b0;
    waitIdle("t2_idle_timeout", 20);
    check("t2_one_handshake", hsCount - hsBefore, 1);

    // Test 3: flush after two beats discards the block, then a normal refill
    reqQ.push_back(32'h0000_0040);
    miss_i = 1'b1; missAddr_i = 32'h0000_0040; memReqReady_i = 1'b1;
    step();
    miss_i = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
      end
      memRespValid_i = 1'b1; memRespData_i = mkBeat(3, b);
      step();
    end
    memRespValid_i = 1'b0;
    @(negedge clk);
    check("t3_idle_after_last", busy_o, 0);
    check("t3_no_write", wrEnable_o, 0);
    check("t3_wrAddr_hold", wrAddr_o, 32'h0000_1220);
    check("t3_block_hold", instBlock_o, mkBlock(2));
    step();
    refill(32'h0000_0080, 32'h0000_0080, 4, 0);

    // Test 4: two-cycle beat gaps while miss_i toggles; no extra request allowed
    reqQ.push_back(32'h0000_2460);
    pushWr(32'h0000_2460, mkBlock(5));
    miss_i = 1'b1; missAddr_i = 32'h0000_2468; memReqReady_i = 1'b1;
    step();
    step();
    for (int b = 0; b < 4; b++) begin
      memRespValid_i = 1'b1; memRespData_i = mkBeat(5, b);
      miss_i = b[0];
      step();
      memRespValid_i = 1'b0;
      if (b < 3) repeat (2) begin
        miss_i = ~miss_i;
        step();
      end
    end
    miss_i = 1'b1;
    step();
    step();
    miss_i = 1'b0;
    @(negedge clk);
    check("t4_idle", busy_o, 0);
    check("t4_block_hold", instBlock_o, mkBlock(5));
    step();

    // Test 5: reset in FILL after beat 1 clears everything; late beats ignored
    reqQ.push_back(32'h0000_3000);
    miss_i = 1'b1; missAddr_i = 32'h0000_3000; memReqReady_i = 1'b1;
    step();
    miss_i = 1'b0;
    step();
    for (int b = 0; b < 2; b++) begin
      memRespValid_i = 1'b1; memRespData_i = mkBeat(6, b);
      step();
    end
    reset = 1'b1; memRespData_i = mkBeat(6, 2);
    step();
    reset = 1'b0; memRespData_i = mkBeat(6, 3);
    @(negedge clk);
    check("t5_reqValid", memReqValid_o, 0);
    check("t5_reqAddr", memReqAddr_o, 0);
    check("t5_wrEnable", wrEnable_o, 0);
    check("t5_wrAddr", wrAddr_o, 0);
    check("t5_block", instBlock_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_timeout", timeout_o, 0);
    step();
    memRespValid_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t5_still_idle", busy_o, 0);
    step();
    refill(32'h0000_3004, 32'h0000_3000, 7, 1);

    // Test 6: only one beat returned
    reqQ.push_back(32'h0000_5000);
    miss_i = 1'b1; missAddr_i = 32'h0000_5010; memReqReady_i = 1'b1;
    step();
    miss_i = 1'b0;
    step();
    memRespValid_i = 1'b1; memRespData_i = mkBeat(8, 0);
    step();
    memRespValid_i = 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("t6_timeout_pulse", timeout_o, (k == 16) ? 1 : 0);
      step();
    end
    @(negedge clk);
    check("t6_busy_after", busy_o, 0);
    check("t6_timeout_single", timeout_o, 0);
    step();
    memRespValid_i = 1'b1;
    repeat (3) step();
    memRespValid_i = 1'b0;
    @(negedge clk);
    check("t6_late_beats_ignored", busy_o, 0);
    step();
    check("t6_timeout_count", toSeen, 1);
`else
    pushWr(32'h0000_5000, mkBlock(8));
    repeat (80) step();
    @(negedge clk);
    check("t6_waits_forever", busy_o, 1);
    check("t6_no_timeout", toSeen, 0);
    step();
    for (int b = 1; b < 4; b++) begin
      memRespValid_i = 1'b1; memRespData_i = mkBeat(8, b);
      step();
    end
    memRespValid_i = 1'b0;
    waitIdle("t6_idle_timeout", 20);
`endif

    repeat (3) step();
    check("end_reqQ_empty", reqQ.size(), 0);
    check("end_wrQ_empty", wrQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
